// File: rtl/mem_rd_streamer_pkg.sv
// mem_rd_streamer_pkg: state encodings shared by the memory-side controllers.
package mem_rd_streamer_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/mem_rd_streamer_sync_fifo.sv
// sync_fifo: first-word-fall-through buffer; push while full is accepted only alongside a pop.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic              do_push, do_pop;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
         count  <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   // storage deliberately unreset; pointers alone define validity
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/mem_rd_streamer.sv
// mem_rd_streamer: reads a burst of words from memory and streams them out,
// issuing requests only while buffered plus in-flight words fit in the FIFO.
module mem_rd_streamer
   import mem_rd_streamer_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W-1:0] len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] mem_rd_addr_o,
   output logic              mem_rd_vld_o,
   input  logic [DATA_W-1:0] mem_rd_data_i,
   input  logic              mem_rd_rdy_i,
   output logic [DATA_W-1:0] m_data_o,
   output logic              m_vld_o,
   input  logic              m_rdy_i
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr, rem;
   logic              inflight, done, issue, push, pop, empty, full;
   logic [CW-1:0]     fifo_cnt;
   assign push = mem_rd_rdy_i && inflight;
   assign pop  = m_rdy_i && !empty;
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      unique case (state)
         IDLE:    state_nxt = start_i ? RUN : IDLE;
         RUN: begin
            issue     = !full && (fifo_cnt + CW'(inflight)) < CW'(FIFO_DEPTH);
            state_nxt = (issue && rem == '0) ? DRAIN : RUN;
         end
         DRAIN:   state_nxt = (!inflight && empty) ? IDLE : DRAIN;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         addr     <= '0;
         rem      <= '0;
         inflight <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         done     <= state == DRAIN && state_nxt == IDLE;
         inflight <= issue || (inflight && !push);
         if (state == IDLE && start_i) begin
            addr <= base_addr_i;
            rem  <= len_i;
         end else if (issue) begin
            addr <= addr + 1'b1;
            rem  <= rem - 1'b1;
         end
      end
   end
   sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (mem_rd_data_i),
      .pop     (pop),
      .rd_data (m_data_o),
      .full    (full),
      .empty   (empty),
      .count   (fifo_cnt)
   );
   assign busy_o        = state != IDLE;
   assign done_o        = done;
   assign mem_rd_addr_o = addr;
   assign mem_rd_vld_o  = issue;
   assign m_vld_o       = !empty;
endmodule

// File: tb/tb_mem_rd_streamer.sv
// tb_mem_rd_streamer: directed burst scenarios with random stream backpressure,
// checked against the expected word list mem[(base+i) mod 256], i = 0..len.
module tb_mem_rd_streamer;
   logic       clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
   logic [7:0] base_addr_i = '0, len_i = '0, mem_rd_data_i = '0;
   logic       mem_rd_rdy_i = 1'b0, m_rdy_i = 1'b0;
   logic       busy_o, done_o, mem_rd_vld_o, m_vld_o;
   logic [7:0] mem_rd_addr_o, m_data_o;

   mem_rd_streamer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .base_addr_i   (base_addr_i),
      .len_i         (len_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .mem_rd_addr_o (mem_rd_addr_o),
      .mem_rd_vld_o  (mem_rd_vld_o),
      .mem_rd_data_i (mem_rd_data_i),
      .mem_rd_rdy_i  (mem_rd_rdy_i),
      .m_data_o      (m_data_o),
      .m_vld_o       (m_vld_o),
      .m_rdy_i       (m_rdy_i)
   );

   always #5 clk = ~clk;

   int         checks = 0, errors = 0, cyc = 0, rdy_mode = 1;
   int         done_cnt, done_busy, max_cnt, first_vld, first_mvld, start_cyc;
   logic [7:0] mem [256];
   logic [7:0] got [$];
   logic [7:0] adr [$];
   int         xfer_cyc [$];
   logic [7:0] b, l;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: sample outputs at negedge, then act as memory and stream sink after posedge
   task automatic tick();
      logic       v;
      logic [7:0] a;
      @(negedge clk);
      v = mem_rd_vld_o;
      a = mem_rd_addr_o;
      if (v) begin
         adr.push_back(a);
         if (first_vld < 0) first_vld = cyc;
      end
      if (m_vld_o && first_mvld < 0) first_mvld = cyc;
      if (m_vld_o && m_rdy_i) begin
         got.push_back(m_data_o);
         xfer_cyc.push_back(cyc);
      end
      if (done_o) begin
         done_cnt++;
         if (busy_o) done_busy++;
      end
      if (int'(dut.fifo_cnt) > max_cnt) max_cnt = int'(dut.fifo_cnt);
      @(posedge clk);
      #1;
      cyc++;
      mem_rd_rdy_i  = v;
      mem_rd_data_i = v ? mem[a] : 8'($urandom);
      m_rdy_i       = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
   endtask

   task automatic start_burst(input logic [7:0] bb, input logic [7:0] ll);
      got.delete();
      adr.delete();
      xfer_cyc.delete();
      done_cnt   = 0;
      done_busy  = 0;
      max_cnt    = 0;
      first_vld  = -1;
      first_mvld = -1;
      start_i     = 1'b1;
      base_addr_i = bb;
      len_i       = ll;
      start_cyc   = cyc;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy_o && n < max) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(busy_o), 0);
      repeat (2) tick();
   endtask

   task automatic check_burst(input string tag, input logic [7:0] bb, input logic [7:0] ll);
      int n = int'(ll) + 1;
      int bad_d = 0, bad_a = 0;
      chk({tag, "_words"}, got.size(), n);
      chk({tag, "_reqs"}, adr.size(), n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] e;
         e = bb + 8'(i);
         if (i >= got.size() || got[i] !== mem[e]) bad_d++;
         if (i >= adr.size() || adr[i] !== e) bad_a++;
      end
      chk({tag, "_data_order"}, bad_d, 0);
      chk({tag, "_addr_order"}, bad_a, 0);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_done_while_busy"}, done_busy, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_req", 32'(mem_rd_vld_o), 0);
      chk("rst_mvld", 32'(m_vld_o), 0);
      chk("rst_addr", 32'(mem_rd_addr_o), 0);
      rst_n    = 1'b1;
      rdy_mode = 1;
      tick();

      start_burst(8'h10, 8'd3);
      wait_idle(50);
      check_burst("basic", 8'h10, 8'd3);
      chk("lat_req", first_vld, start_cyc + 1);
      chk("lat_data", first_mvld, start_cyc + 3);
      chk("throughput", (xfer_cyc.size() == 4) ? xfer_cyc[3] - xfer_cyc[0] : -1, 3);

      start_burst(8'hFE, 8'd3);
      wait_idle(50);
      check_burst("wrap", 8'hFE, 8'd3);

      rdy_mode = 0;
      start_burst(8'h80, 8'd7);
      repeat (12) tick();
      chk("stall_reqs", adr.size(), 4);
      chk("stall_req_low", 32'(mem_rd_vld_o), 0);
      chk("stall_out", got.size(), 0);
      chk("stall_full", 32'(dut.fifo_cnt), 4);
      rdy_mode = 1;
      wait_idle(50);
      check_burst("stall", 8'h80, 8'd7);

      rdy_mode = 2;
      b = 8'($urandom);
      start_burst(b, 8'hFF);
      wait_idle(3000);
      check_burst("long", b, 8'hFF);
      chk("fifo_bound", 32'(max_cnt <= 4), 1);

      repeat (4) begin
         b = 8'($urandom);
         l = 8'($urandom_range(0, 20));
         start_burst(b, l);
         wait_idle(500);
         check_burst("rand", b, l);
      end

      start_burst(8'h20, 8'd5);
      repeat (2) tick();
      start_i     = 1'b1;
      base_addr_i = 8'h90;
      len_i       = 8'd2;
      tick();
      start_i = 1'b0;
      wait_idle(200);
      check_burst("ignore_start", 8'h20, 8'd5);

      rdy_mode = 1;
      start_burst(8'h30, 8'd7);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy_o), 0);
      chk("midrst_done", 32'(done_o), 0);
      chk("midrst_req", 32'(mem_rd_vld_o), 0);
      chk("midrst_mvld", 32'(m_vld_o), 0);
      chk("midrst_addr", 32'(mem_rd_addr_o), 0);
      mem_rd_rdy_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n         = 1'b1;
      mem_rd_rdy_i  = 1'b1;
      mem_rd_data_i = 8'hEE;
      start_burst(8'h40, 8'd1);
      wait_idle(50);
      check_burst("post_rst", 8'h40, 8'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
